// File: rtl/hilo_muldiv_sequencer_pkg.sv
// hilo_pkg: shared types for the HI/LO multiply/divide sequencer.
//   op_e    - operation codes issued by the EX stage
//   state_e - sequencer FSM states
//   is_signed_op / is_div_op - operation class decoders
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Operations whose operands are two's complement and need sign handling.
  function automatic logic is_signed_op(op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Operations that run the restoring-divide step instead of shift-add.
  function automatic logic is_div_op(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// hilo_muldiv_sequencer_if: EX-stage <-> HI/LO sequencer bundle.
//   start/op/rs_data/rt_data - instruction issue (EX -> sequencer)
//   read_hilo/flush          - MFHI/MFLO present, EX squash
//   busy/stall/done          - status back to the pipeline / hazard unit
//   hi_reg/lo_reg            - architectural HI and LO
interface hilo_muldiv_sequencer_if
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             read_hilo;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  modport master (
    output start, op, rs_data, rt_data, read_hilo, flush,
    input  busy, stall, done, hi_reg, lo_reg
  );

  modport slave (
    input  start, op, rs_data, rt_data, read_hilo, flush,
    output busy, stall, done, hi_reg, lo_reg
  );

endinterface

// File: rtl/hilo_muldiv_sequencer_step.sv
// muldiv_step_unit: one combinational iteration of the HI/LO datapath.
//   is_div_i       - 1: restoring-divide step, 0: shift-add multiply step
//   hi_i/lo_i      - running accumulator {hi,lo}
//                    (multiply: partial product / remaining multiplier;
//                     divide: partial remainder / dividend-then-quotient)
//   opnd_i         - multiplicand or divisor (magnitude)
//   hi_o/lo_o      - accumulator after this iteration
module muldiv_step_unit #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;
  logic             fits_s;

  // Single multiply or divide iteration selected by is_div_i.
  always_comb begin
    sum_s     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shifted_s = {hi_i, lo_i[WIDTH-1]};
    fits_s    = (shifted_s >= {1'b0, opnd_i});
    // When the divisor fits, the true difference is below 2^WIDTH, so the
    // low WIDTH bits of the subtraction are exact.
    diff_s    = shifted_s[WIDTH-1:0] - opnd_i;
    if (is_div_i) begin
      hi_o = fits_s ? diff_s : shifted_s[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], fits_s};
    end else begin
      hi_o = sum_s[WIDTH:1];
      lo_o = {sum_s[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: owns HI/LO and sequences iterative mul/div.
//   clk_i  - clock, rising edge
//   rst_ni - synchronous active-low reset
//   bus    - slave side of hilo_muldiv_sequencer_if (issue, status, HI/LO)
// Accepted mul/div ops run WIDTH iterations in RUN, then one FIX cycle applies
// sign correction / accumulation and writes HI/LO. MTHI/MTLO write directly.
module hilo_muldiv_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  hilo_muldiv_sequencer_if.slave   bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d, busy_q, busy_d, done_q, done_d;

  logic               accept_s, sa_s, sb_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s, step_hi_s, step_lo_s, quo_s, rem_s;
  logic [2*WIDTH-1:0] prod_fix_s, hilo_s;

  assign accept_s = bus.start & ~bus.flush & (state_q == IDLE);
  assign sa_s     = is_signed_op(bus.op) & bus.rs_data[WIDTH-1];
  assign sb_s     = is_signed_op(bus.op) & bus.rt_data[WIDTH-1];
  assign abs_a_s  = sa_s ? ({WIDTH{1'b0}} - bus.rs_data) : bus.rs_data;
  assign abs_b_s  = sb_s ? ({WIDTH{1'b0}} - bus.rt_data) : bus.rt_data;

  // Signed product, quotient and remainder from the magnitude results. With a
  // zero divisor the remainder path returns the dividend unchanged, so only the
  // quotient needs forcing to all-ones.
  assign prod_fix_s = neg_res_q ? ({(2*WIDTH){1'b0}} - {acc_hi_q, acc_lo_q})
                                : {acc_hi_q, acc_lo_q};
  assign quo_s  = div_zero_q ? {WIDTH{1'b1}}
                : (neg_res_q ? ({WIDTH{1'b0}} - acc_lo_q) : acc_lo_q);
  assign rem_s  = neg_rem_q ? ({WIDTH{1'b0}} - acc_hi_q) : acc_hi_q;
  assign hilo_s = {hi_q, lo_q};

  muldiv_step_unit #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_op(op_q)),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi_s),
    .lo_o     (step_lo_s)
  );

  // Next-state and datapath update for the IDLE/RUN/FIX sequencer.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (bus.op)
            OP_MTHI: begin
              hi_d   = bus.rs_data;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.rs_data;
              done_d = 1'b1;
            end
            default: begin
              op_d       = bus.op;
              acc_hi_d   = {WIDTH{1'b0}};
              // Divide shifts the dividend out of LO; multiply shifts the
              // multiplier out of LO.
              acc_lo_d   = is_div_op(bus.op) ? abs_a_s : abs_b_s;
              opnd_d     = is_div_op(bus.op) ? abs_b_s : abs_a_s;
              neg_res_d  = sa_s ^ sb_s;
              neg_rem_d  = sa_s;
              div_zero_d = (bus.rt_data == {WIDTH{1'b0}});
              cnt_d      = CNT_W'(WIDTH);
              state_d    = RUN;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_hi_d = step_hi_s;
        acc_lo_d = step_lo_s;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        case (op_q)
          OP_MADD:        {hi_d, lo_d} = hilo_s + prod_fix_s;
          OP_MSUB:        {hi_d, lo_d} = hilo_s - prod_fix_s;
          OP_DIV, OP_DIVU: begin
            hi_d = rem_s;
            lo_d = quo_s;
          end
          default:        {hi_d, lo_d} = prod_fix_s;
        endcase
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and HI/LO registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      cnt_q      <= {CNT_W{1'b0}};
      acc_hi_q   <= {WIDTH{1'b0}};
      acc_lo_q   <= {WIDTH{1'b0}};
      opnd_q     <= {WIDTH{1'b0}};
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Stall holds back MFHI/MFLO or a new HI/LO op until the result lands.
  assign bus.stall  = busy_q & (bus.read_hilo | bus.start);
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi_reg = hi_q;
  assign bus.lo_reg = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer: hand-computed HI/LO results,
// latency, stall window, reset abort and flushed issue.
module tb_hilo_muldiv_sequencer;
  import hilo_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   stall_cnt;
  int   done_cnt;
  logic found;

  hilo_muldiv_sequencer_if #(.WIDTH(32)) bus ();

  hilo_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op for a single accept edge; returns just after that edge.
  task automatic start_op(input op_e op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // From cycle start_cyc, wait for Done (bounded), counting Stall-high cycles.
  task automatic wait_done(input int start_cyc, output int n, output logic seen, output int stalls);
    n      = start_cyc;
    seen   = 1'b0;
    stalls = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.stall === 1'b1) stalls++;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int   n;
    int   s;
    logic seen;
    start_op(op, a, b);
    wait_done(1, n, seen, s);
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_latency"}, 64'(n), 64'd34);
    check({tag, "_hi"}, {32'd0, bus.hi_reg}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, bus.lo_reg}, {32'd0, exp_lo});
    check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.op        = OP_MULT;
    bus.rs_data   = 32'd0;
    bus.rt_data   = 32'd0;
    bus.read_hilo = 1'b0;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_stall", {63'd0, bus.stall}, 64'd0);
    check("rst_hi", {32'd0, bus.hi_reg}, 64'd0);
    check("rst_lo", {32'd0, bus.lo_reg}, 64'd0);
    rst_n = 1'b1;

    // Arithmetic results (HI/LO carried between MULT/MADD and DIV/MSUB).
    run_op("multu", OP_MULTU, 32'h0000_00C8, 32'h0000_00C8, 32'h0000_0000, 32'h0000_9C40);
    run_op("mult",  OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("madd",  OP_MADD,  32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000);
    run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", OP_DIVU,  32'h0000_012C, 32'h0000_0000, 32'h0000_012C, 32'hFFFF_FFFF);
    run_op("divov", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("msub",  OP_MSUB,  32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0000, 32'h8000_0006);

    // MFHI/MFLO waiting from accept+3: stall cycles 4..33, released with Done.
    start_op(OP_MULTU, 32'd3, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    bus.read_hilo = 1'b1;
    wait_done(4, cyc, found, stall_cnt);
    check("rd_done_seen", {63'd0, found}, 64'd1);
    check("rd_latency", 64'(cyc), 64'd34);
    check("rd_stall_cycles", 64'(stall_cnt), 64'd30);
    check("rd_stall_at_done", {63'd0, bus.stall}, 64'd0);
    check("rd_lo", {32'd0, bus.lo_reg}, 64'd15);
    @(posedge clk);
    #1;
    bus.read_hilo = 1'b0;

    // MTLO issued while busy: stalls, is not taken early, then lands.
    start_op(OP_MULTU, 32'd2, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.op      = OP_MTLO;
    bus.rs_data = 32'h0000_0064;
    bus.rt_data = 32'd0;
    wait_done(4, cyc, found, stall_cnt);
    check("mtlo_done_seen", {63'd0, found}, 64'd1);
    check("mtlo_stall_cycles", 64'(stall_cnt), 64'd30);
    check("mtlo_mul_lo", {32'd0, bus.lo_reg}, 64'd6);
    check("mtlo_stall_at_done", {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("mtlo_done", {63'd0, bus.done}, 64'd1);
    check("mtlo_lo", {32'd0, bus.lo_reg}, 64'h64);
    check("mtlo_busy", {63'd0, bus.busy}, 64'd0);

    // Reset sampled at accept+10 discards a DIV in flight.
    start_op(OP_DIV, 32'd100, 32'd7);
    bus.read_hilo = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstop_busy_before", {63'd0, bus.busy}, 64'd1);
    check("rstop_stall_before", {63'd0, bus.stall}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("rstop_busy", {63'd0, bus.busy}, 64'd0);
    check("rstop_stall", {63'd0, bus.stall}, 64'd0);
    check("rstop_hi", {32'd0, bus.hi_reg}, 64'd0);
    check("rstop_lo", {32'd0, bus.lo_reg}, 64'd0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.read_hilo = 1'b0;
    done_cnt      = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("rstop_no_done", 64'(done_cnt), 64'd0);

    // MTHI accepted normally, then a flushed MTHI is ignored.
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.op      = OP_MTHI;
    bus.rs_data = 32'h0000_1111;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("mthi_done", {63'd0, bus.done}, 64'd1);
    check("mthi_hi", {32'd0, bus.hi_reg}, 64'h1111);
    check("mthi_busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.flush   = 1'b1;
    bus.op      = OP_MTHI;
    bus.rs_data = 32'h0000_AAEE;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_hi", {32'd0, bus.hi_reg}, 64'h1111);
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_done", {63'd0, bus.done}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
